seven_seg_rx: RTL and testbench

Receiver for the multiplexed two-digit seven-segment Pmod bus. It samples the 8-line bus (7 active-low segments plus digit select), decodes each segment pattern back to a nibble and reassembles the displayed byte. The block sits on a Pmod input or a loopback tap beside the display controller, for self-test and for reading a second board's display.

---
 rtl/seven_seg_rx_if.sv | 13 +
 rtl/seven_seg_rx.sv | 191 +++++++++++++++++++
 tb/tb_seven_seg_rx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seven_seg_rx_if.sv
// Bus bundle for the seven-segment receiver: raw Pmod lines in, decoded byte
// and status out. The receiver takes the slave side; the source of seg_in
// (pins model, loopback tap) takes the master side.
interface seven_seg_rx_if;
   logic [7:0] seg_in;
   logic [7:0] dout;
   logic       dout_valid;
   logic       err;
   logic       stale;

   modport master (output seg_in, input dout, dout_valid, err, stale);
   modport slave  (input seg_in, output dout, dout_valid, err, stale);
endinterface

// File: rtl/seven_seg_rx.sv
// Receiver for the multiplexed two-digit seven-segment Pmod bus.
// Synchronizes the 8 raw lines, waits for SETTLE_CYCLES identical samples,
// decodes the segment pattern to a nibble and pairs LSB/MSB digits into a
// byte. A watchdog raises stale when no digit is accepted for
// 2^TIMEOUT_BITS cycles.
// Optional build macro: SEVEN_SEG_RX_CHANGE_ONLY_EN -- suppress re-emission
// of a byte equal to the current dout.
module seven_seg_rx #(
   parameter int SETTLE_CYCLES = 4,
   parameter int TIMEOUT_BITS  = 20
) (
   input logic          CLK,
   input logic          RST_N,
   seven_seg_rx_if.slave bus
);

   localparam logic [7:0] SETTLE_C  = 8'(SETTLE_CYCLES);
   localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYCLES - 1);
   localparam logic [TIMEOUT_BITS-1:0] TMO_MAX  = '1;
   localparam logic [TIMEOUT_BITS-1:0] TMO_NEAR = TMO_MAX - 1'b1;

   typedef enum logic [1:0] {EMPTY, HAVE_LSB, HAVE_MSB} state_t;

   logic [7:0] sync1_q, s_q, s_prev_q;
   logic [7:0] cnt_q;
   logic       accept;

   // Two-flop synchronizer plus stability counter; the flops reset to a
   // blank LSB-select pattern.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q  <= 8'hFF;
         s_q      <= 8'hFF;
         s_prev_q <= 8'hFF;
         cnt_q    <= 8'd0;
      end else begin
         sync1_q  <= bus.seg_in;
         s_q      <= sync1_q;
         s_prev_q <= s_q;
         if (s_q != s_prev_q)
            cnt_q <= 8'd0;
         else if (cnt_q != SETTLE_C)
            cnt_q <= cnt_q + 8'd1;
      end
   end

   // Accept fires once, on the edge where the count reaches SETTLE_CYCLES;
   // after that the counter sits saturated until the bus changes.
   assign accept = (s_q == s_prev_q) && (cnt_q == SETTLE_M1);

   logic [6:0] seg_act;
   logic [3:0] dec_nib;
   logic       dec_ok;
   logic       sel_lsb;

   assign seg_act = ~s_q[6:0];
   assign sel_lsb = s_q[7];

   // Segment pattern (active-high gfedcba) to hex nibble.
   always_comb begin
      dec_ok  = 1'b1;
      dec_nib = 4'h0;
      case (seg_act)
         7'h3F: dec_nib = 4'h0;
         7'h06: dec_nib = 4'h1;
         7'h5B: dec_nib = 4'h2;
         7'h4F: dec_nib = 4'h3;
         7'h66: dec_nib = 4'h4;
         7'h6D: dec_nib = 4'h5;
         7'h7D: dec_nib = 4'h6;
         7'h07: dec_nib = 4'h7;
         7'h7F: dec_nib = 4'h8;
         7'h6F: dec_nib = 4'h9;
         7'h77: dec_nib = 4'hA;
         7'h7C: dec_nib = 4'hB;
         7'h39: dec_nib = 4'hC;
         7'h5E: dec_nib = 4'hD;
         7'h79: dec_nib = 4'hE;
         7'h71: dec_nib = 4'hF;
         default: dec_ok = 1'b0;
      endcase
   end

   logic [TIMEOUT_BITS-1:0] tmo_q;
   logic                    expire;

   // Watchdog: cleared by any accept, saturates at all-ones.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         tmo_q <= '0;
      else if (accept)
         tmo_q <= '0;
      else if (tmo_q != TMO_MAX)
         tmo_q <= tmo_q + 1'b1;
   end

   // An accept in the expiry cycle takes precedence over the timeout.
   assign expire = (tmo_q == TMO_NEAR) && !accept;

   state_t     state_q, state_d;
   logic [3:0] hold_q, hold_d;
   logic [7:0] dout_q, dout_d;
   logic       vld_q, vld_d;
   logic       err_q, err_d;
   logic       stale_q, stale_d;
   logic [7:0] pair;
   logic       pair_rdy;
   logic       emit_ok;

   // Assembly state, held nibble and registered outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= EMPTY;
         hold_q  <= 4'h0;
         dout_q  <= 8'h00;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         stale_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         dout_q  <= dout_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
         stale_q <= stale_d;
      end
   end

   // Next-state and output logic: pair an LSB with an MSB digit in either
   // order; a repeat of the same select overwrites the held nibble.
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      stale_d  = stale_q;
      pair     = 8'h00;
      pair_rdy = 1'b0;
      err_d    = 1'b0;
      if (accept) begin
         stale_d = 1'b0;
         if (!dec_ok) begin
            err_d   = 1'b1;
            state_d = EMPTY;
         end else begin
            case (state_q)
               HAVE_LSB: begin
                  if (sel_lsb) begin
                     hold_d = dec_nib;
                  end else begin
                     pair     = {dec_nib, hold_q};
                     pair_rdy = 1'b1;
                     state_d  = EMPTY;
                  end
               end
               HAVE_MSB: begin
                  if (!sel_lsb) begin
                     hold_d = dec_nib;
                  end else begin
                     pair     = {hold_q, dec_nib};
                     pair_rdy = 1'b1;
                     state_d  = EMPTY;
                  end
               end
               default: begin
                  hold_d  = dec_nib;
                  state_d = sel_lsb ? HAVE_LSB : HAVE_MSB;
               end
            endcase
         end
      end else if (expire) begin
         stale_d = 1'b1;
         state_d = EMPTY;
      end
   end

   // Emission gate: optionally drop a byte identical to the one on dout.
   always_comb begin
`ifdef SEVEN_SEG_RX_CHANGE_ONLY_EN
      emit_ok = pair_rdy && (pair != dout_q);
`else
      emit_ok = pair_rdy;
`endif
      dout_d = emit_ok ? pair : dout_q;
      vld_d  = emit_ok;
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = vld_q;
   assign bus.err        = err_q;
   assign bus.stale      = stale_q;

endmodule

// File: tb/tb_seven_seg_rx.sv
// Directed bench for seven_seg_rx: SETTLE_CYCLES=4, TIMEOUT_BITS=6.
module tb_seven_seg_rx;
   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   vld_cnt = 0;
   int   err_cnt = 0;
   int   last_vld_cyc = 0;
   int   drv_cyc = 0;
   int   v0, e0;
   int   exp_co;

   seven_seg_rx_if bus ();

   seven_seg_rx #(.SETTLE_CYCLES(4), .TIMEOUT_BITS(6)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Pulse counters sampled mid-cycle.
   always @(negedge CLK) begin
      if (bus.dout_valid) begin
         vld_cnt      = vld_cnt + 1;
         last_vld_cyc = cyc;
      end
      if (bus.err) err_cnt = err_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] enc(input logic sel, input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
         4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
         4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
         4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
      endcase
      return {sel, ~p};
   endfunction

   // Called at a falling edge: put v on the pins for n rising edges.
   task automatic drive(input logic [7:0] v, input int n);
      bus.seg_in = v;
      drv_cyc    = cyc;
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bus.seg_in = enc(1'b1, 4'h9);
      repeat (3) @(negedge CLK);
      chk("rst_dout", 32'(bus.dout), 32'h00);
      chk("rst_vld", 32'(bus.dout_valid), 32'h0);
      chk("rst_err", 32'(bus.err), 32'h0);
      chk("rst_stale", 32'(bus.stale), 32'h0);
      RST_N = 1'b1;

      // Basic byte 0x39 with latency check on the MSB digit.
      v0 = vld_cnt; e0 = err_cnt;
      drive(enc(1'b1, 4'h9), 20);
      drive(enc(1'b0, 4'h3), 20);
      chk("basic_vld_cnt", 32'(vld_cnt - v0), 32'd1);
      chk("basic_dout", 32'(bus.dout), 32'h39);
      chk("basic_latency", 32'(last_vld_cyc), 32'(drv_cyc + 7));
      chk("basic_err", 32'(err_cnt - e0), 32'd0);

      // 3-cycle glitch between digits is ignored.
      v0 = vld_cnt; e0 = err_cnt;
      drive(enc(1'b1, 4'h5), 20);
      drive(enc(1'b1, 4'h8), 3);
      drive(enc(1'b0, 4'h6), 20);
      chk("glitch_dout", 32'(bus.dout), 32'h65);
      chk("glitch_vld_cnt", 32'(vld_cnt - v0), 32'd1);
      chk("glitch_err", 32'(err_cnt - e0), 32'd0);

      // Blank pattern errors and discards the held LSB.
      v0 = vld_cnt; e0 = err_cnt;
      drive(enc(1'b1, 4'h1), 20);
      drive(8'h7F, 10);
      chk("undec_err", 32'(err_cnt - e0), 32'd1);
      drive(enc(1'b0, 4'h7), 20);
      chk("undec_empty", 32'(vld_cnt - v0), 32'd0);
      drive(enc(1'b1, 4'h3), 20);
      chk("undec_dout", 32'(bus.dout), 32'h73);
      chk("undec_vld_cnt", 32'(vld_cnt - v0), 32'd1);

      // Overwrite of a held LSB.
      v0 = vld_cnt;
      drive(enc(1'b1, 4'h5), 20);
      drive(enc(1'b1, 4'h8), 20);
      drive(enc(1'b0, 4'hA), 20);
      chk("ovw_dout", 32'(bus.dout), 32'hA8);
      chk("ovw_vld_cnt", 32'(vld_cnt - v0), 32'd1);

      // Timeout discards the held LSB; next accept clears stale.
      v0 = vld_cnt;
      drive(enc(1'b1, 4'h9), 80);
      chk("tmo_stale_set", 32'(bus.stale), 32'h1);
      drive(enc(1'b0, 4'h2), 20);
      chk("tmo_stale_clr", 32'(bus.stale), 32'h0);
      chk("tmo_discard", 32'(vld_cnt - v0), 32'd0);
      drive(enc(1'b1, 4'h1), 20);
      chk("tmo_dout", 32'(bus.dout), 32'h21);
      chk("tmo_vld_cnt", 32'(vld_cnt - v0), 32'd1);

      // Repeated identical pair.
`ifdef SEVEN_SEG_RX_CHANGE_ONLY_EN
      exp_co = 1;
`else
      exp_co = 3;
`endif
      v0 = vld_cnt;
      for (int i = 0; i < 3; i++) begin
         drive(enc(1'b0, 4'h4), 20);
         drive(enc(1'b1, 4'h2), 20);
      end
      chk("co_vld_cnt", 32'(vld_cnt - v0), 32'(exp_co));
      chk("co_dout", 32'(bus.dout), 32'h42);

      // Asynchronous reset while holding an MSB digit.
      drive(enc(1'b0, 4'h6), 20);
      #3;
      RST_N      = 1'b0;
      bus.seg_in = enc(1'b1, 4'h4);
      #1;
      chk("mid_rst_dout", 32'(bus.dout), 32'h00);
      chk("mid_rst_vld", 32'(bus.dout_valid), 32'h0);
      chk("mid_rst_err", 32'(bus.err), 32'h0);
      chk("mid_rst_stale", 32'(bus.stale), 32'h0);
      @(negedge CLK);
      RST_N = 1'b1;
      v0 = vld_cnt;
      drive(enc(1'b1, 4'h4), 20);
      drive(enc(1'b0, 4'h5), 20);
      chk("post_rst_dout", 32'(bus.dout), 32'h54);
      chk("post_rst_vld_cnt", 32'(vld_cnt - v0), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
